// File: rtl/periodic_read_issuer.sv
// Periodic-read initiator: an interval timer triggers a round-robin pick of the next enabled bank,
// then holds a one-hot request to the per-bank command generators until that bank accepts.
module periodic_read_issuer #(
  parameter int NUM_BANKS      = 16,
  parameter int ROW_WIDTH      = 18,
  parameter int INTERVAL_WIDTH = 16,
  parameter int TIMEOUT        = 64,
  parameter int TCQ            = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [INTERVAL_WIDTH-1:0] interval_cfg,
  input  logic [NUM_BANKS-1:0]      bank_mask,
  input  logic                      cfg_open_mode,
  output logic                      per_rd_req,
  output logic [NUM_BANKS-1:0]      inject_select,
  output logic                      inject_open,
  output logic [ROW_WIDTH-1:0]      inject_row,
  input  logic [NUM_BANKS-1:0]      per_rd_accept,
  output logic                      busy,
  output logic                      stall,
  output logic [31:0]               issued_cnt
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                    state_r, state_s;
  logic [INTERVAL_WIDTH-1:0] timer_r, timer_s;
  logic [BANK_W-1:0]         last_bank_r, last_bank_s;
  logic [BANK_W-1:0]         sel_bank_r, sel_bank_s;
  logic [ROW_WIDTH-1:0]      row_ptr_r, row_ptr_s;
  logic [WAIT_W-1:0]         wait_cnt_r, wait_cnt_s;
  logic                      req_r, req_s, open_r, open_s, busy_r, busy_s, stall_r, stall_s;
  logic [NUM_BANKS-1:0]      select_r, select_s;
  logic [ROW_WIDTH-1:0]      row_r, row_s;
  logic [31:0]               issued_r, issued_s;
  logic [BANK_W-1:0]         next_bank_s, top_bank_s, cand_s;
  logic                      found_s, fire_s, accept_s;
  logic                      tcq_unused_s;

  // Clock-to-q is a simulation-only notion; keep the parameter referenced for interface compatibility
  assign tcq_unused_s = (TCQ != 32'sd0);

  // Round-robin search from the bank after the last served one, plus highest enabled bank for row wrap
  always_comb begin
    next_bank_s = last_bank_r;
    top_bank_s  = {BANK_W{1'b0}};
    cand_s      = {BANK_W{1'b0}};
    found_s     = 1'b0;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      cand_s      = last_bank_r + BANK_W'(i);
      next_bank_s = (!found_s && bank_mask[cand_s]) ? cand_s : next_bank_s;
      found_s     = found_s | bank_mask[cand_s];
    end
    for (int i = 0; i < NUM_BANKS; i++) begin
      top_bank_s = bank_mask[i] ? BANK_W'(i) : top_bank_s;
    end
  end

  assign fire_s   = (state_r == IDLE) && enable && (timer_r == {INTERVAL_WIDTH{1'b0}})
                    && (bank_mask != {NUM_BANKS{1'b0}});
  assign accept_s = (state_r == REQ) && ((per_rd_accept & select_r) != {NUM_BANKS{1'b0}});

  // Next-state and output computation
  always_comb begin
    state_s     = state_r;
    timer_s     = timer_r;
    last_bank_s = last_bank_r;
    sel_bank_s  = sel_bank_r;
    row_ptr_s   = row_ptr_r;
    wait_cnt_s  = wait_cnt_r;
    req_s       = req_r;
    select_s    = select_r;
    open_s      = open_r;
    row_s       = row_r;
    busy_s      = busy_r;
    stall_s     = stall_r;
    issued_s    = issued_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_s    = REQ;
          sel_bank_s = next_bank_s;
          req_s      = 1'b1;
          select_s   = {{(NUM_BANKS-1){1'b0}}, 1'b1} << next_bank_s;
          row_s      = row_ptr_r;
          open_s     = cfg_open_mode;
          busy_s     = 1'b1;
          wait_cnt_s = {WAIT_W{1'b0}};
        end else if (enable && (timer_r != {INTERVAL_WIDTH{1'b0}})) begin
          timer_s = timer_r - {{(INTERVAL_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          timer_s = timer_r;
        end
      end
      REQ: begin
        if (accept_s) begin
          state_s     = IDLE;
          req_s       = 1'b0;
          select_s    = {NUM_BANKS{1'b0}};
          busy_s      = 1'b0;
          stall_s     = 1'b0;
          last_bank_s = sel_bank_r;
          issued_s    = issued_r + 32'd1;
          timer_s     = interval_cfg;
          // The row advances once the sweep has reached the top enabled bank
          if ((bank_mask != {NUM_BANKS{1'b0}}) && (sel_bank_r == top_bank_s)) begin
            row_ptr_s = row_ptr_r + {{(ROW_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            row_ptr_s = row_ptr_r;
          end
        end else begin
          if (wait_cnt_r != WAIT_W'(TIMEOUT)) begin
            wait_cnt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end else begin
            wait_cnt_s = wait_cnt_r;
          end
          if (wait_cnt_r == WAIT_W'(TIMEOUT - 1)) begin
            stall_s = 1'b1;
          end else begin
            stall_s = stall_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      timer_r     <= interval_cfg;
      last_bank_r <= BANK_W'(NUM_BANKS - 1);
      sel_bank_r  <= {BANK_W{1'b0}};
      row_ptr_r   <= {ROW_WIDTH{1'b0}};
      wait_cnt_r  <= {WAIT_W{1'b0}};
      req_r       <= 1'b0;
      select_r    <= {NUM_BANKS{1'b0}};
      open_r      <= 1'b0;
      row_r       <= {ROW_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      stall_r     <= 1'b0;
      issued_r    <= 32'd0;
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      last_bank_r <= last_bank_s;
      sel_bank_r  <= sel_bank_s;
      row_ptr_r   <= row_ptr_s;
      wait_cnt_r  <= wait_cnt_s;
      req_r       <= req_s;
      select_r    <= select_s;
      open_r      <= open_s;
      row_r       <= row_s;
      busy_r      <= busy_s;
      stall_r     <= stall_s;
      issued_r    <= issued_s;
    end
  end

  assign per_rd_req    = req_r;
  assign inject_select = select_r;
  assign inject_open   = open_r;
  assign inject_row    = row_r;
  assign busy          = busy_r;
  assign stall         = stall_r;
  assign issued_cnt    = issued_r;

endmodule

// File: tb/tb_periodic_read_issuer.sv
// Directed bench for periodic_read_issuer: expected requests are queued as stimulus is set up
// and compared when the DUT raises per_rd_req.
module tb_periodic_read_issuer;

  logic        clk = 1'b0;
  logic        rst_n, enable, cfg_open_mode;
  logic [15:0] interval_cfg, bank_mask, per_rd_accept;
  logic        per_rd_req, inject_open, busy, stall;
  logic [15:0] inject_select;
  logic [17:0] inject_row;
  logic [31:0] issued_cnt;

  typedef struct {
    logic [15:0] sel;
    logic [17:0] row;
    logic        open;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;
  logic saw;

  periodic_read_issuer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .interval_cfg(interval_cfg),
    .bank_mask(bank_mask), .cfg_open_mode(cfg_open_mode), .per_rd_req(per_rd_req),
    .inject_select(inject_select), .inject_open(inject_open), .inject_row(inject_row),
    .per_rd_accept(per_rd_accept), .busy(busy), .stall(stall), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int bank, input int row, input logic open);
    exp_t e;
    e.sel  = 16'h0001 << bank;
    e.row  = 18'(row);
    e.open = open;
    exp_q.push_back(e);
  endtask

  task automatic wait_req(input string tag, input int max, output int n);
    exp_t e;
    n = 0;
    while (per_rd_req !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check({tag, "_req"}, per_rd_req, 1);
    check({tag, "_sb"}, (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_sel"}, inject_select, e.sel);
      check({tag, "_row"}, inject_row, e.row);
      check({tag, "_open"}, inject_open, e.open);
      check({tag, "_busy"}, busy, 1);
    end
  endtask

  task automatic accept(input int bank);
    per_rd_accept = 16'h0001 << bank;
    tick();
    per_rd_accept = 16'h0000;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, per_rd_req, 0);
    check({tag, "_sel"}, inject_select, 0);
    check({tag, "_open"}, inject_open, 0);
    check({tag, "_row"}, inject_row, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_cnt"}, issued_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; interval_cfg = 16'd4; bank_mask = 16'h0005;
    cfg_open_mode = 1'b0; per_rd_accept = 16'h0000;
    tick(); tick();
    check_zero("reset");
    rst_n = 1'b1; enable = 1'b1;

    // Round-robin over banks 0 and 2, row advancing after bank2
    push(0, 0, 1'b0); wait_req("t1a", 20, lat); check("t1a_lat", lat, 5);
    tick(); tick(); accept(0);
    check("t1a_drop", per_rd_req, 0); check("t1a_idle_sel", inject_select, 0);
    check("t1a_cnt", issued_cnt, 1);
    push(2, 0, 1'b0); wait_req("t1b", 20, lat); check("t1b_lat", lat, 5);
    tick(); tick(); accept(2);
    check("t1b_cnt", issued_cnt, 2);
    push(0, 1, 1'b0); wait_req("t1c", 20, lat); check("t1c_lat", lat, 5);
    tick(); tick(); accept(0);
    check("t1c_cnt", issued_cnt, 3);

    // Accept on a non-selected bank is ignored
    push(2, 1, 1'b0); wait_req("t2", 20, lat); check("t2_lat", lat, 5);
    accept(3);
    check("t2_ign_req", per_rd_req, 1); check("t2_ign_sel", inject_select, 16'h0004);
    accept(2);
    check("t2_drop", per_rd_req, 0); check("t2_cnt", issued_cnt, 4);

    // Stall after TIMEOUT cycles without accept
    push(0, 2, 1'b0); wait_req("t3", 20, lat);
    repeat (63) tick();
    check("t3_stall_early", stall, 0);
    tick();
    check("t3_stall_64", stall, 1);
    check("t3_hold_sel", inject_select, 16'h0001); check("t3_hold_row", inject_row, 2);
    check("t3_hold_req", per_rd_req, 1);
    repeat (6) tick();
    check("t3_stall_70", stall, 1);
    accept(0);
    check("t3_clr_stall", stall, 0); check("t3_clr_req", per_rd_req, 0);
    check("t3_cnt", issued_cnt, 5);

    // Empty mask never fires; then bank15 alone with zero interval
    rst_n = 1'b0; bank_mask = 16'h0000; tick(); rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      tick();
      saw = saw | per_rd_req;
    end
    check("t4_no_req", saw, 0);
    bank_mask = 16'h8000; interval_cfg = 16'd0;
    push(15, 0, 1'b0); wait_req("t4", 5, lat); check("t4_lat", lat, 1);
    accept(15);
    check("t5_drop0", per_rd_req, 0);
    push(15, 1, 1'b0); wait_req("t5a", 1, lat); check("t5a_lat", lat, 1);
    cfg_open_mode = 1'b1; tick();
    check("t5_open_held", inject_open, 0); check("t5_req_held", per_rd_req, 1);
    accept(15);
    check("t5_drop1", per_rd_req, 0); check("t5_open_idle", inject_open, 0);
    push(15, 2, 1'b1); wait_req("t5b", 1, lat); check("t5b_lat", lat, 1);

    // Reset while a request is outstanding
    interval_cfg = 16'd4; rst_n = 1'b0; tick();
    check_zero("t6_rst");
    rst_n = 1'b1; cfg_open_mode = 1'b0; bank_mask = 16'h0011;
    push(0, 0, 1'b0); wait_req("t6", 20, lat); check("t6_lat", lat, 5);
    accept(0);
    check("t6_cnt", issued_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
